motion_timer_arbiter: RTL and testbench

//   Shares one prescaled tick timer between NUM_REQ requesters (drive, turn, arm, buzzer).

---
 rtl/timer_sched_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 37 +++
 rtl/motion_timer_arbiter.sv | 167 ++++++++++++++++
 tb/tb_motion_timer_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared definitions for the motion timer arbiter: state encoding,
// default prescale ratio and a width helper used for counters and pointers.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    // 1 ms tick at a 100 MHz system clock
    localparam int DEF_TICK_DIV = 100000;

    // Bits needed to hold values 0..value-1; never returns less than 1
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
// clr is synchronous and wins over en; tick is only ever high while en is high.
module tick_prescaler
    import timer_sched_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..TICK_DIV-1 while enabled, wrapping on the tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/motion_timer_arbiter.sv
// Round-robin owner of one shared tick timer for drive/turn/arm/buzzer.
// Optional feature macro: TIMER_ABORT_EN adds an abort input that cancels
// the running hold without a done pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no owner; pick next requester at/after ptr, latch its dur
// ST_RUN  | owner holds the timer; remaining counts down on each tick
// ST_DONE | one-cycle done pulse to the owner, ptr moves past it
module motion_timer_arbiter
    import timer_sched_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int NUM_REQ  = 4,
    parameter int DUR_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef TIMER_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DUR_W-1:0] dur,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     tick,
    output logic [DUR_W-1:0]         remaining
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    timer_state_t state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DUR_W-1:0]   rem_q, rem_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [DUR_W-1:0]   pick_dur;
    logic [PTR_W-1:0]   owner_next;
    logic               presc_clr;
    logic               presc_en;
    logic               presc_tick;
    logic               abort_req;

`ifdef TIMER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Empty hold (dur 0) never enables the prescaler, so it cannot tick
    assign presc_en = (state_q == ST_RUN) && (rem_q != '0);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (presc_clr),
        .en    (presc_en),
        .tick  (presc_tick)
    );

    assign owner_next = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);

    // Round-robin search starting at ptr, wrapping past NUM_REQ-1
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_dur   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(idx);
                pick_dur   = dur[idx*DUR_W +: DUR_W];
            end
        end
    end

    // Next-state and datapath updates for grant, countdown and done
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rem_d     = rem_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        presc_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                rem_d = '0;
                if (pick_valid) begin
                    owner_d         = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    rem_d           = pick_dur;
                    presc_clr       = 1'b1;
                    state_d         = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    gnt_d     = '0;
                    rem_d     = '0;
                    ptr_d     = owner_next;
                    presc_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rem_q == '0) begin
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (presc_tick) begin
                    rem_d = rem_q - DUR_W'(1);
                    if (rem_q == DUR_W'(1)) begin
                        done_d  = gnt_q;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = owner_next;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                rem_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves req[0] with top priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign remaining = rem_q;
    assign busy      = (state_q != ST_IDLE);
    assign tick      = presc_tick;

endmodule

// File: tb/tb_motion_timer_arbiter.sv
// Bench for motion_timer_arbiter with TICK_DIV=4, NUM_REQ=4, DUR_W=8.
// Expected owners come from a round-robin model over the pending-request
// mask; expected hold lengths come from dur*TICK_DIV arithmetic.
module tb_motion_timer_arbiter;

    localparam int TD  = 4;
    localparam int NR  = 4;
    localparam int DW  = 8;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] dur;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic            busy;
    logic            tick;
    logic [DW-1:0]   remaining;
`ifdef TIMER_ABORT_EN
    logic            abort;
`endif

    int total;
    int bad;
    int ptr;

    motion_timer_arbiter #(
        .TICK_DIV (TD),
        .NUM_REQ  (NR),
        .DUR_W    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef TIMER_ABORT_EN
        .abort     (abort),
`endif
        .req       (req),
        .dur       (dur),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .tick      (tick),
        .remaining (remaining)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_rem", 32'(remaining), 0);
        reset = 1'b1;
        ptr   = 0;
    endtask

    // Called in the first grant cycle; returns in the done cycle
    task automatic run_grant(input string tag, input int idx, input int d,
                             input bit drop_mid, input bit scramble);
        int k;
        int ticks;
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << idx));
        chk({tag, "_rem0"}, 32'(remaining), 32'(d));
        chk({tag, "_busy"}, 32'(busy), 1);
        k = 0;
        ticks = 0;
        while (done == '0 && k < 200) begin
            chk({tag, "_rem"}, 32'(remaining), 32'(d - ticks));
            chk({tag, "_hold"}, 32'(gnt), 32'(1 << idx));
            if (tick) ticks++;
            step();
            k++;
            if (k == 1) begin
                if (drop_mid) req[idx] = 1'b0;
                if (scramble) dur[idx*DW +: DW] = 8'($urandom);
            end
        end
        chk({tag, "_cycles"}, 32'(k), 32'((d == 0) ? 1 : d * TD));
        chk({tag, "_ticks"}, 32'(ticks), 32'(d));
        chk({tag, "_done"}, 32'(done), 32'(1 << idx));
        chk({tag, "_gnt_done"}, 32'(gnt), 32'(1 << idx));
        chk({tag, "_rem_done"}, 32'(remaining), 0);
        chk({tag, "_tick_done"}, 32'(tick), 0);
        ptr = (idx + 1) % NR;
    endtask

    task automatic finish_idle(input string tag);
        step();
        chk({tag, "_idle_gnt"}, 32'(gnt), 0);
        chk({tag, "_idle_done"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_rem"}, 32'(remaining), 0);
    endtask

    initial begin
        int w;
        int n;
        logic [NR-1:0] nb;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        req   = '0;
        dur   = '0;
`ifdef TIMER_ABORT_EN
        abort = 1'b0;
`endif
        do_reset();

        // single requester, 3 ticks
        req = 4'b0001;
        dur[0*DW +: DW] = 8'd3;
        step();
        run_grant("t1", 0, 3, 1'b0, 1'b0);
        req = '0;
        finish_idle("t1");

        // zero duration: two grant cycles, no tick
        req = 4'b0100;
        dur[2*DW +: DW] = 8'd0;
        step();
        run_grant("t3", 2, 0, 1'b0, 1'b0);
        req = '0;
        finish_idle("t3");

        // owner drops req mid-hold, pending req1 follows two cycles after done
        do_reset();
        req = 4'b0011;
        dur[0*DW +: DW] = 8'd2;
        dur[1*DW +: DW] = 8'd1;
        step();
        run_grant("t6a", 0, 2, 1'b1, 1'b0);
        finish_idle("t6a");
        step();
        run_grant("t6b", 1, 1, 1'b0, 1'b0);
        req = '0;
        finish_idle("t6b");

        // all four held, rotate 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NR; i++) dur[i*DW +: DW] = 8'd1;
        for (int i = 0; i < 5; i++) begin
            w = pick(req, ptr);
            step();
            run_grant("t2", w, 1, 1'b0, 1'b0);
            chk("t2_order", 32'(w), 32'(i % NR));
            if (i == 4) req = '0;
            finish_idle("t2");
        end

        // reset in the middle of a hold
        do_reset();
        req = 4'b0010;
        dur[1*DW +: DW] = 8'd5;
        step();
        chk("t4_gnt", 32'(gnt), 32'b0010);
        n = 0;
        w = 0;
        while (w < 2 && n < 100) begin
            if (tick) w++;
            if (w < 2) begin
                step();
                n++;
            end
        end
        chk("t4_tick2_seen", 32'(w), 2);
        reset = 1'b0;
        #1;
        chk("t4_rst_gnt", 32'(gnt), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_rem", 32'(remaining), 0);
        chk("t4_rst_tick", 32'(tick), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_rst_done", 32'(done), 0);
        end
        req = 4'b0011;
        dur[0*DW +: DW] = 8'd1;
        reset = 1'b1;
        ptr = 0;
        step();
        run_grant("t4a", 0, 1, 1'b0, 1'b0);
        req[0] = 1'b0;
        finish_idle("t4a");
        step();
        run_grant("t4b", 1, 5, 1'b0, 1'b0);
        req = '0;
        finish_idle("t4b");

`ifdef TIMER_ABORT_EN
        // abort after the 4th tick of a 10-tick hold
        req = 4'b1000;
        dur[3*DW +: DW] = 8'd10;
        step();
        chk("t5_gnt", 32'(gnt), 32'b1000);
        n = 0;
        w = 0;
        while (w < 4 && n < 100) begin
            if (tick) w++;
            if (w < 4) begin
                step();
                n++;
            end
        end
        chk("t5_tick4_seen", 32'(w), 4);
        abort = 1'b1;
        req = '0;
        step();
        abort = 1'b0;
        chk("t5_gnt_drop", 32'(gnt), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_rem", 32'(remaining), 0);
        chk("t5_busy", 32'(busy), 0);
        step();
        chk("t5_done_late", 32'(done), 0);
        ptr = 0;
`endif

        // randomized traffic against the round-robin model
        req = 4'b0000;
        for (int t = 0; t < 30; t++) begin
            if (req == '0) begin
                w = $urandom_range(NR - 1);
                dur[w*DW +: DW] = 8'($urandom_range(3));
                req[w] = 1'b1;
            end
            w = pick(req, ptr);
            step();
            run_grant("rnd", w, int'(dur[w*DW +: DW]), 1'($urandom_range(1)), 1'($urandom_range(1)));
            req[w] = 1'b0;
            nb = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (nb[i] && !req[i]) begin
                    dur[i*DW +: DW] = 8'($urandom_range(3));
                    req[i] = 1'b1;
                end
            end
            finish_idle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
